// File: rtl/pll_rst_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
// Holds the FSM state encoding and the counter-width function used to size counters.
`timescale 1ns/1ps
package pll_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_PWRDN     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_STAGGER   = 3'd3,
    ST_RUN       = 3'd4
  } state_t;

  localparam int RELOCK_W = 8;

  // Bits needed to hold values 0..val, i.e. ceil(log2(val+1)), never less than 1.
  function automatic int cnt_width(input int unsigned val);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((val >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pll_rst_seq_if.sv
// Status bundle between the sequencer core and its consumers.
// The master drives the reset/powerdown outputs and receives the lock indication.
`timescale 1ns/1ps
interface pll_rst_seq_if;
  import pll_rst_seq_pkg::*;

  logic                lock;
  logic                pll_powerdown;
  logic                sys_rst;
  logic                cpu_rst;
  logic                locked;
  logic [RELOCK_W-1:0] relock_cnt;

  modport master (
    input  lock,
    output pll_powerdown, sys_rst, cpu_rst, locked, relock_cnt
  );

  modport slave (
    output lock,
    input  pll_powerdown, sys_rst, cpu_rst, locked, relock_cnt
  );
endinterface

// File: rtl/pll_rst_seq_fsm.sv
// Sequencer core: PLL powerdown/restart FSM with staged reset release.
// Every output is registered from the next state, so no lock input reaches an output combinationally.
`timescale 1ns/1ps
module pll_rst_seq_fsm
  import pll_rst_seq_pkg::*;
#(
  parameter int PD_CYCLES      = 64,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CPU_STAGGER    = 16
) (
  input  logic          clk,
  input  logic          srst,
  pll_rst_seq_if.master bus
);

  localparam int PD_W  = cnt_width(PD_CYCLES);
  localparam int TO_W  = cnt_width(TIMEOUT_CYCLES);
  localparam int ST_W  = cnt_width(STABLE_CYCLES);
  localparam int STG_W = cnt_width(CPU_STAGGER);

  localparam logic [PD_W-1:0]  PD_LAST  = PD_W'(PD_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(CPU_STAGGER - 1);
  // The WAIT_LOCK cycle that first saw lock is the first of the consecutive lock cycles.
  localparam logic [ST_W-1:0]  ST_LAST  = ST_W'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);

  state_t              r_state;
  state_t              w_state_next;
  logic                w_restart;
  logic                w_entry;
  logic [PD_W-1:0]     r_pd_cnt;
  logic [TO_W-1:0]     r_to_cnt;
  logic [ST_W-1:0]     r_st_cnt;
  logic [STG_W-1:0]    r_stg_cnt;
  logic                r_pd;
  logic                r_sys_rst;
  logic                r_cpu_rst;
  logic                r_locked;
  logic [RELOCK_W-1:0] r_relock;

  always_ff @(posedge clk) begin
    if (srst) r_state <= ST_PWRDN;
    else      r_state <= w_state_next;
  end

  // A single restart flag keeps a coincident lock loss and timeout from counting twice.
  always_comb begin
    w_state_next = r_state;
    w_restart    = 1'b0;
    case (r_state)
      ST_PWRDN: begin
        if (r_pd_cnt == PD_LAST) w_state_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (bus.lock) begin
          w_state_next = ST_STABLE;
        end else if (r_to_cnt == TO_LAST) begin
          w_state_next = ST_PWRDN;
          w_restart    = 1'b1;
        end
      end
      ST_STABLE: begin
        if (!bus.lock)              w_state_next = ST_WAIT_LOCK;
        else if (r_st_cnt >= ST_LAST) w_state_next = ST_STAGGER;
      end
      ST_STAGGER: begin
        if (!bus.lock) begin
          w_state_next = ST_PWRDN;
          w_restart    = 1'b1;
        end else if (r_stg_cnt == STG_LAST) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!bus.lock) begin
          w_state_next = ST_PWRDN;
          w_restart    = 1'b1;
        end
      end
      default: w_state_next = ST_PWRDN;
    endcase
  end

  assign w_entry = (w_state_next != r_state);

  always_ff @(posedge clk) begin
    if (srst || w_entry)          r_pd_cnt <= '0;
    else if (r_state == ST_PWRDN) r_pd_cnt <= r_pd_cnt + PD_W'(1);
  end

  always_ff @(posedge clk) begin
    if (srst || w_entry)              r_to_cnt <= '0;
    else if (r_state == ST_WAIT_LOCK) r_to_cnt <= r_to_cnt + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (srst || w_entry)           r_st_cnt <= '0;
    else if (r_state == ST_STABLE) r_st_cnt <= r_st_cnt + ST_W'(1);
  end

  always_ff @(posedge clk) begin
    if (srst || w_entry)            r_stg_cnt <= '0;
    else if (r_state == ST_STAGGER) r_stg_cnt <= r_stg_cnt + STG_W'(1);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      r_pd      <= 1'b1;
      r_sys_rst <= 1'b1;
      r_cpu_rst <= 1'b1;
      r_locked  <= 1'b0;
      r_relock  <= '0;
    end else begin
      r_pd      <= (w_state_next == ST_PWRDN);
      r_sys_rst <= (w_state_next == ST_PWRDN) || (w_state_next == ST_WAIT_LOCK) ||
                   (w_state_next == ST_STABLE);
      r_cpu_rst <= (w_state_next != ST_RUN);
      r_locked  <= (w_state_next == ST_RUN);
      if (w_restart && (r_relock != {RELOCK_W{1'b1}})) r_relock <= r_relock + RELOCK_W'(1);
    end
  end

  assign bus.pll_powerdown = r_pd;
  assign bus.sys_rst       = r_sys_rst;
  assign bus.cpu_rst       = r_cpu_rst;
  assign bus.locked        = r_locked;
  assign bus.relock_cnt    = r_relock;

endmodule

// File: rtl/sync2.sv
// Generic two-flop synchronizer for a single-bit level crossing into clk.
// Both stages clear on srst so no stale level survives a reset.
`timescale 1ns/1ps
module sync2 (
  input  logic clk,
  input  logic srst,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_d};
    end
  end

  assign o_q = r_sync[1];

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer top: synchronizes PLL lock and drives staged bus/CPU resets.
// Runs entirely on the free-running crystal clock so it works while the PLL is down.
`timescale 1ns/1ps
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int PD_CYCLES      = 64,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CPU_STAGGER    = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                pll_lock_i,
  output logic                pll_powerdown_o,
  output logic                sys_rst_o,
  output logic                cpu_rst_o,
  output logic                locked_o,
  output logic [RELOCK_W-1:0] relock_cnt_o
);

  logic w_lock_s;

  pll_rst_seq_if u_bus ();

  sync2 u_lock_sync (
    .clk  (wb_clk_i),
    .srst (wb_rst_i),
    .i_d  (pll_lock_i),
    .o_q  (w_lock_s)
  );

  assign u_bus.lock = w_lock_s;

  pll_rst_seq_fsm #(
    .PD_CYCLES      (PD_CYCLES),
    .STABLE_CYCLES  (STABLE_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CPU_STAGGER    (CPU_STAGGER)
  ) u_fsm (
    .clk  (wb_clk_i),
    .srst (wb_rst_i),
    .bus  (u_bus.master)
  );

  assign pll_powerdown_o = u_bus.pll_powerdown;
  assign sys_rst_o       = u_bus.sys_rst;
  assign cpu_rst_o       = u_bus.cpu_rst;
  assign locked_o        = u_bus.locked;
  assign relock_cnt_o    = u_bus.relock_cnt;

endmodule
